// File: rtl/join_pkg.sv
// Shared types for the join merge stage: FSM state enums and the default packet width.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package join_pkg;

    localparam int JOIN_DW = 32;

    // Input side: idle, or holding ack high toward the producer just captured.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACK_A = 2'd1,
        ACK_B = 2'd2
    } in_state_t;

    // Output side: offering the head, or waiting for the consumer to drop ack.
    typedef enum logic {
        O_REQ = 1'b0,
        O_RTZ = 1'b1
    } out_state_t;

endpackage

// File: rtl/join_merge_if.sv
// Handshake bundle between two producers, the arbiter grants and one consumer.
// Latency: n/a (wiring only).
// Backpressure: four-phase send/ack on each side; slave = merge stage, master = its environment.
interface join_merge_if #(parameter int DW = join_pkg::JOIN_DW);

    logic          in_a_send;
    logic [DW-1:0] in_a_data;
    logic          in_a_ack;
    logic          in_b_send;
    logic [DW-1:0] in_b_data;
    logic          in_b_ack;
    logic          grant_a;
    logic          grant_b;
    logic          out_send;
    logic [DW-1:0] out_data;
    logic          out_ack;
    logic          grant_err;

    modport slave (
        input  in_a_send, in_a_data, in_b_send, in_b_data,
        input  grant_a, grant_b, out_ack,
        output in_a_ack, in_b_ack, out_send, out_data, grant_err
    );

    modport master (
        output in_a_send, in_a_data, in_b_send, in_b_data,
        output grant_a, grant_b, out_ack,
        input  in_a_ack, in_b_ack, out_send, out_data, grant_err
    );

endinterface

// File: rtl/join_fifo.sv
// Small circular-buffer FIFO holding captured packets; rdata reads as zero when empty.
// Latency: a push is visible at rdata the cycle after the write edge.
// Backpressure: full/empty reported to the caller; push while full or pop while empty is ignored.
// Ports: CLK, MR_n (async active-low), push/wdata (write), pop (advance head), rdata/full/empty.
module join_fifo #(
    parameter int DW    = join_pkg::JOIN_DW,
    parameter int DEPTH = 2
) (
    input  logic          CLK,
    input  logic          MR_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Storage carries no reset; stale entries are masked by the empty check below.
    always_ff @(posedge CLK) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/join_merge.sv
// Merges two granted four-phase producers into one four-phase consumer through a small FIFO.
// Latency: capture at end of cycle N, in_x_ack and out_send (if FIFO was empty) both high in N+1.
// Backpressure: a full FIFO withholds capture; the consumer's ack paces pops, one per handshake.
// Ports: CLK, MR_n (async active-low), bus (join_merge_if.slave: in_a/in_b send/data/ack,
//        grant_a/grant_b, out_send/out_data/out_ack, sticky grant_err).
module join_merge
    import join_pkg::*;
#(
    parameter int DW    = JOIN_DW,
    parameter int DEPTH = 2
) (
    input  logic         CLK,
    input  logic         MR_n,
    join_merge_if.slave  bus
);

    in_state_t     in_state;
    out_state_t    out_state;
    logic          a_ack_q;
    logic          b_ack_q;
    logic          grant_err_q;

    logic          take_a;
    logic          take_b;
    logic          push;
    logic          pop;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;
    logic          full;
    logic          empty;
    logic          out_send_c;

    // A wins whenever both producers are eligible in the same cycle.
    assign take_a = (in_state == IDLE) & bus.in_a_send & bus.grant_a & ~full;
    assign take_b = (in_state == IDLE) & bus.in_b_send & bus.grant_b & ~full & ~take_a;
    assign push   = take_a | take_b;
    assign wdata  = take_a ? bus.in_a_data : bus.in_b_data;

    // Ack flops are set/cleared alongside the state so the ack pins come straight from flops.
    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            in_state    <= IDLE;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            grant_err_q <= 1'b0;
        end else begin
            if (bus.grant_a & bus.grant_b) begin
                grant_err_q <= 1'b1;
            end
            case (in_state)
                IDLE: begin
                    if (take_a) begin
                        in_state <= ACK_A;
                        a_ack_q  <= 1'b1;
                    end else if (take_b) begin
                        in_state <= ACK_B;
                        b_ack_q  <= 1'b1;
                    end
                end
                ACK_A: begin
                    if (!bus.in_a_send) begin
                        in_state <= IDLE;
                        a_ack_q  <= 1'b0;
                    end
                end
                ACK_B: begin
                    if (!bus.in_b_send) begin
                        in_state <= IDLE;
                        b_ack_q  <= 1'b0;
                    end
                end
                default: begin
                    in_state <= IDLE;
                    a_ack_q  <= 1'b0;
                    b_ack_q  <= 1'b0;
                end
            endcase
        end
    end

    // out_send is a gate of two flop-based terms, so reset clears it without a clock edge.
    assign out_send_c = ~empty & (out_state == O_REQ);
    assign pop        = out_send_c & bus.out_ack;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            out_state <= O_REQ;
        end else begin
            case (out_state)
                O_REQ: begin
                    if (pop) begin
                        out_state <= O_RTZ;
                    end
                end
                O_RTZ: begin
                    if (!bus.out_ack) begin
                        out_state <= O_REQ;
                    end
                end
                default: out_state <= O_REQ;
            endcase
        end
    end

    join_fifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .MR_n  (MR_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    assign bus.in_a_ack  = a_ack_q;
    assign bus.in_b_ack  = b_ack_q;
    assign bus.out_send  = out_send_c;
    assign bus.out_data  = rdata;
    assign bus.grant_err = grant_err_q;

endmodule
